// File: rtl/fma16_normround.sv
// fma16_normround: normalize, round and pack the fmaadd raw sum into binary16.
// S1 counts leading zeros and shifts; S2 rounds, adjusts the exponent and packs.
module fma16_normround #(
    parameter int NF  = 10,
    parameter int NE  = 5,
    parameter int SMW = 22,
    parameter int SEW = 7
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [SMW-1:0] in_sm,
    input  logic [SEW-1:0] in_se,
    input  logic           in_ss,
    input  logic           in_sticky,
    input  logic           in_zsign,
    input  logic           in_nan,
    input  logic           in_inf,
    input  logic           in_invalid,
    input  logic [1:0]     roundmode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [NE+NF:0] result,
    output logic [3:0]     flags
);

    typedef struct packed {
        logic [NF:0] sig;
        logic        g;
        logic        s;
        logic [8:0]  re;
        logic        sign;
        logic [1:0]  mode;
        logic        nan;
        logic        inf;
        logic        zero;
        logic        inv;
        logic        zsign;
    } s1_t;

    s1_t            s1_d, s1_q;
    logic           s1_valid_d, s1_valid_q;
    logic           s2_valid_d, s2_valid_q;
    logic [NE+NF:0] result_d, result_q;
    logic [3:0]     flags_d, flags_q;

    logic           s1_adv, s2_adv;

    // S1 datapath
    logic [4:0]        lead;
    logic [8:0]        re;
    logic [8:0]        neg;
    logic [4:0]        sh;
    logic [SMW-1:0]    norm;
    logic [SMW+23:0]   ext;

    // S2 datapath
    logic              lsb, inexact, inc, tiny, ovf, to_inf;
    logic [NF+1:0]     rsum;
    logic [8:0]        e;
    logic [NF-1:0]     frac;
    logic [NE+NF:0]    pk_res;
    logic [3:0]        pk_flg;

    assign s2_adv    = ~s2_valid_q | out_ready;
    assign s1_adv    = ~s1_valid_q | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    always_comb begin
        lead = '0;
        for (int i = 0; i < SMW; i++) begin
            if (in_sm[i]) lead = 5'(i);
        end
        re   = {{(9-SEW){in_se[SEW-1]}}, in_se} + {4'b0, lead} - 9'd20;
        neg  = '0;
        sh   = '0;
        // Subnormal: align so bit NF carries weight 2^-14
        if (re[8] || re == 9'd0) begin
            neg = 9'd1 - re;
            sh  = (neg > 9'd24) ? 5'd24 : neg[4:0];
        end
        norm = in_sm << (5'd21 - lead);
        ext  = {norm, 24'b0} >> sh;

        s1_d.sig   = ext[SMW+23 -: NF+1];
        s1_d.g     = ext[SMW+12];
        s1_d.s     = (|ext[SMW+11:0]) | in_sticky;
        s1_d.re    = re;
        s1_d.sign  = in_ss;
        s1_d.mode  = roundmode;
        s1_d.nan   = in_nan;
        s1_d.inf   = in_inf;
        s1_d.zero  = (in_sm == '0) & ~in_sticky;
        s1_d.inv   = in_invalid;
        s1_d.zsign = in_zsign;

        if (!(s1_adv && in_valid)) s1_d = s1_q;
        s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    end

    always_comb begin
        lsb     = s1_q.sig[0];
        inexact = s1_q.g | s1_q.s;
        inc     = 1'b0;
        unique case (s1_q.mode)
            2'b00: inc = 1'b0;
            2'b01: inc = s1_q.g & (s1_q.s | lsb);
            2'b10: inc = s1_q.sign & inexact;
            2'b11: inc = ~s1_q.sign & inexact;
        endcase

        rsum = {1'b0, s1_q.sig} + {{(NF+1){1'b0}}, inc};
        tiny = s1_q.re[8] | (s1_q.re == 9'd0);
        if (tiny) begin
            e    = {8'b0, rsum[NF]};
            frac = rsum[NF-1:0];
        end else if (rsum[NF+1]) begin
            e    = s1_q.re + 9'd1;
            frac = rsum[NF:1];
        end else begin
            e    = s1_q.re;
            frac = rsum[NF-1:0];
        end

        ovf    = ~e[8] & (e >= 9'd31);
        to_inf = (s1_q.mode == 2'b01)
               | ((s1_q.mode == 2'b11) & ~s1_q.sign)
               | ((s1_q.mode == 2'b10) & s1_q.sign);

        if (s1_q.nan) begin
            pk_res = 16'h7E00;
            pk_flg = {s1_q.inv, 3'b000};
        end else if (s1_q.inf) begin
            pk_res = {s1_q.sign, 15'h7C00};
            pk_flg = {s1_q.inv, 3'b000};
        end else if (s1_q.zero) begin
            pk_res = {s1_q.zsign, 15'h0000};
            pk_flg = {s1_q.inv, 3'b000};
        end else if (ovf) begin
            pk_res = {s1_q.sign, to_inf ? 15'h7C00 : 15'h7BFF};
            pk_flg = {s1_q.inv, 3'b101};
        end else begin
            pk_res = {s1_q.sign, e[NE-1:0], frac};
            pk_flg = {s1_q.inv, 1'b0, tiny & inexact, inexact};
        end

        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        result_d   = result_q;
        flags_d    = flags_q;
        if (s2_adv && s1_valid_q) begin
            result_d = pk_res;
            flags_d  = pk_flg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
        end
    end

endmodule
